// File: rtl/input_conditioner_if.sv
// Port bundle for input_conditioner: raw board inputs toward the conditioner and
// conditioned, debounced signals back toward the calculator core.
interface input_conditioner_if;
  // next_pulse and sw_changed are single-cycle strobes with no ready/backpressure.
  // The consumer must sample them on every clock. The *_db outputs and next_held are
  // levels that are valid on every cycle.
  logic       next_raw;
  logic       clear_raw;
  logic       level_raw;
  logic [2:0] ms_raw;
  logic [3:0] din_raw;

  logic       next_pulse;
  logic       next_held;
  logic       clear_db;
  logic       level_db;
  logic [2:0] ms_db;
  logic [3:0] din_db;
  logic       sw_changed;
  logic [1:0] btn_state;

  modport master (
    output next_raw, clear_raw, level_raw, ms_raw, din_raw,
    input  next_pulse, next_held, clear_db, level_db, ms_db, din_db, sw_changed, btn_state
  );

  modport slave (
    input  next_raw, clear_raw, level_raw, ms_raw, din_raw,
    output next_pulse, next_held, clear_db, level_db, ms_db, din_db, sw_changed, btn_state
  );
endinterface

// File: rtl/input_conditioner.sv
// Board-input front end: a two-flop synchronizer and debouncer for the active-low "next"
// button (one step pulse per press) and for the 9-bit switch bank (updated as one unit).
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input_conditioner_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  logic             next_s1, next_s2;
  logic [8:0]       sw_raw_vec;
  logic [8:0]       sw_s1, sw_s2, sw_prev;
  logic [8:0]       sw_db;
  logic             sw_changed_q;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] scnt;
  logic             next_pulse_q;
  logic             next_held_q;

  assign sw_raw_vec = {bus.clear_raw, bus.level_raw, bus.ms_raw, bus.din_raw};

  // The button synchronizer resets to 1 (released) so reset release never looks like a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      next_s1 <= 1'b1;
      next_s2 <= 1'b1;
      sw_s1   <= '0;
      sw_s2   <= '0;
    end else begin
      next_s1 <= bus.next_raw;
      next_s2 <= next_s1;
      sw_s1   <= sw_raw_vec;
      sw_s2   <= sw_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      next_pulse_q <= 1'b0;
      next_held_q  <= 1'b0;
    end else begin
      next_pulse_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!next_s2) begin
            state <= ST_PRESS_WAIT;
            cnt   <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (next_s2) begin
            state <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            state        <= ST_HELD;
            next_pulse_q <= 1'b1;
            next_held_q  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (next_s2) begin
            state <= ST_RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        ST_RELEASE_WAIT: begin
          // A bounce back to 0 returns to HELD; only PRESS_WAIT can emit a pulse.
          if (!next_s2) begin
            state <= ST_HELD;
          end else if (cnt == CNT_LAST) begin
            state       <= ST_IDLE;
            next_held_q <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Any change of the synced vector restarts the stability window; the outputs load
  // together only after the whole vector has held still long enough.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_prev      <= '0;
      scnt         <= '0;
      sw_db        <= '0;
      sw_changed_q <= 1'b0;
    end else begin
      sw_prev      <= sw_s2;
      sw_changed_q <= 1'b0;
      if (sw_s2 != sw_prev) begin
        scnt <= '0;
      end else begin
        if (scnt < CNT_LAST) begin
          scnt <= scnt + CNT_W'(1);
        end
        if ((scnt == CNT_LAST) && (sw_s2 != sw_db)) begin
          sw_db        <= sw_s2;
          sw_changed_q <= 1'b1;
        end
      end
    end
  end

  assign bus.next_pulse = next_pulse_q;
  assign bus.next_held  = next_held_q;
  assign bus.clear_db   = sw_db[8];
  assign bus.level_db   = sw_db[7];
  assign bus.ms_db      = sw_db[6:4];
  assign bus.din_db     = sw_db[3:0];
  assign bus.sw_changed = sw_changed_q;
  assign bus.btn_state  = state;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=4. A run-length reference model
// predicts every output on every cycle; the scenario tasks also check the documented latencies.
module tb_input_conditioner;

  localparam int D  = 4;
  localparam int CW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  input_conditioner_if ic ();

  input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ic.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  // ---------------- reference model ----------------
  // Each input is accepted once its synchronized value has been seen unchanged on D+1
  // consecutive edges. Synchronized value = raw value sampled two edges earlier.
  logic       b_d1, b_d2;
  logic [8:0] v_d1, v_d2;
  logic       m_brun_v;
  int         m_brun_n;
  logic [8:0] m_vrun_v;
  int         m_vrun_n;
  logic       m_pressed, m_pulse, m_changed;
  logic [8:0] m_out;
  int         bn_nx, vn_nx;
  logic [8:0] raw_vec;
  logic       press_ok, release_ok, load_ok;

  assign raw_vec = {ic.clear_raw, ic.level_raw, ic.ms_raw, ic.din_raw};

  always_comb begin
    bn_nx = 1;
    vn_nx = 1;
    if (b_d2 == m_brun_v) bn_nx = (m_brun_n >= D + 1) ? D + 1 : m_brun_n + 1;
    if (v_d2 == m_vrun_v) vn_nx = (m_vrun_n >= D + 1) ? D + 1 : m_vrun_n + 1;
    press_ok   = !m_pressed && !b_d2 && (bn_nx >= D + 1);
    release_ok =  m_pressed &&  b_d2 && (bn_nx >= D + 1);
    load_ok    = (vn_nx >= D + 1) && (v_d2 != m_out);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_d1 <= 1'b1;  b_d2 <= 1'b1;
      v_d1 <= '0;    v_d2 <= '0;
      m_brun_v <= 1'b1; m_brun_n <= 1;
      m_vrun_v <= '0;   m_vrun_n <= 1;
      m_pressed <= 1'b0; m_pulse <= 1'b0; m_changed <= 1'b0; m_out <= '0;
    end else begin
      b_d1 <= ic.next_raw; b_d2 <= b_d1;
      v_d1 <= raw_vec;     v_d2 <= v_d1;
      m_brun_v <= b_d2;    m_brun_n <= bn_nx;
      m_vrun_v <= v_d2;    m_vrun_n <= vn_nx;
      m_pulse   <= press_ok;
      m_changed <= load_ok;
      if (press_ok) m_pressed <= 1'b1;
      else if (release_ok) m_pressed <= 1'b0;
      if (load_ok) m_out <= v_d2;
    end
  end

  logic [11:0] act_vec, exp_vec;
  assign act_vec = {ic.next_pulse, ic.next_held, ic.sw_changed,
                    ic.clear_db, ic.level_db, ic.ms_db, ic.din_db};
  assign exp_vec = {m_pulse, m_pressed, m_changed, m_out};

  // ---------------- driver tasks ----------------
  task automatic set_sw(input logic c, input logic l, input logic [2:0] ms, input logic [3:0] din);
    ic.clear_raw = c;
    ic.level_raw = l;
    ic.ms_raw    = ms;
    ic.din_raw   = din;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    int first_pulse;
    rst = 1'b0;
    ic.next_raw = 1'b0;
    set_sw(1'b1, 1'b1, 3'h7, 4'hF);
    repeat (4) @(negedge clk);
    checks++;
    if (act_vec !== 12'h000) begin
      failures++; $display("FAIL reset_hold actual=%h required=%h", act_vec, 12'h000);
    end
    rst = 1'b1;
    first_pulse = -1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec) begin
        failures++; $display("FAIL reset_model k=%0d actual=%h required=%h", k, act_vec, exp_vec);
      end
      if (k < D + 2) begin
        checks++;
        if (act_vec !== 12'h000) begin
          failures++; $display("FAIL reset_quiet k=%0d actual=%h required=%h", k, act_vec, 12'h000);
        end
      end
      if (ic.next_pulse && first_pulse < 0) first_pulse = k;
    end
    checks++;
    if (first_pulse !== D + 2) begin
      failures++; $display("FAIL reset_first_pulse actual=%0d required=%0d", first_pulse, D + 2);
    end
    checks++;
    if (act_vec[8:0] !== 9'h1FF) begin
      failures++; $display("FAIL reset_sw_load actual=%h required=%h", act_vec[8:0], 9'h1FF);
    end
    ic.next_raw = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec) begin
        failures++; $display("FAIL reset_release k=%0d actual=%h required=%h", k, act_vec, exp_vec);
      end
    end
  endtask

  task automatic test_clean_press;
    int pulses, pidx;
    pulses = 0; pidx = -1;
    ic.next_raw = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec) begin
        failures++; $display("FAIL press_model k=%0d actual=%h required=%h", k, act_vec, exp_vec);
      end
      if (ic.next_pulse) begin pulses++; pidx = k; end
      if (k == D + 1 || k == D + 2) begin
        checks++;
        if (ic.next_held !== (k == D + 2)) begin
          failures++; $display("FAIL press_held_rise k=%0d actual=%b required=%b", k, ic.next_held, k == D + 2);
        end
      end
    end
    checks++;
    if (pulses !== 1 || pidx !== D + 2) begin
      failures++; $display("FAIL press_pulse count=%0d idx=%0d required count=1 idx=%0d", pulses, pidx, D + 2);
    end
    ic.next_raw = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec) begin
        failures++; $display("FAIL release_model k=%0d actual=%h required=%h", k, act_vec, exp_vec);
      end
      if (k == D + 1 || k == D + 2) begin
        checks++;
        if (ic.next_held !== (k == D + 1)) begin
          failures++; $display("FAIL release_held_fall k=%0d actual=%b required=%b", k, ic.next_held, k == D + 1);
        end
      end
    end
  endtask

  task automatic test_bounce;
    int pulses, pidx, hidx;
    pulses = 0; pidx = -1; hidx = -1;
    for (int k = 0; k < 28; k++) begin
      ic.next_raw = (k < 8) ? logic'((k >> 1) & 1) : 1'b0;
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec) begin
        failures++; $display("FAIL bounce_model k=%0d actual=%h required=%h", k, act_vec, exp_vec);
      end
      if (ic.next_pulse) begin pulses++; pidx = k; end
    end
    checks++;
    if (pulses !== 1 || pidx !== 8 + D + 2) begin
      failures++; $display("FAIL bounce_pulse count=%0d idx=%0d required count=1 idx=%0d", pulses, pidx, 8 + D + 2);
    end
    pulses = 0;
    for (int k = 0; k < 24; k++) begin
      ic.next_raw = (k == 2 || k == 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec) begin
        failures++; $display("FAIL rbounce_model k=%0d actual=%h required=%h", k, act_vec, exp_vec);
      end
      if (ic.next_pulse) pulses++;
      if (!ic.next_held && hidx < 0) hidx = k;
    end
    checks++;
    if (pulses !== 0 || hidx !== 4 + D + 2) begin
      failures++; $display("FAIL rbounce_release pulses=%0d held_drop=%0d required pulses=0 held_drop=%0d", pulses, hidx, 4 + D + 2);
    end
  endtask

  task automatic test_switch;
    int changes, cidx, glitches;
    logic [8:0] want;
    set_sw(1'b0, 1'b0, 3'h0, 4'h0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec) begin
        failures++; $display("FAIL sw_clear_model k=%0d actual=%h required=%h", k, act_vec, exp_vec);
      end
    end
    changes = 0; cidx = -1;
    ic.din_raw = 4'b1011;
    exp_q.push_back(9'h00B);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec) begin
        failures++; $display("FAIL sw_model k=%0d actual=%h required=%h", k, act_vec, exp_vec);
      end
      if (ic.sw_changed) begin
        changes++; cidx = k;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL sw_unexpected k=%0d actual=%h required=none", k, act_vec[8:0]);
        end else begin
          want = exp_q.pop_front();
          if (act_vec[8:0] !== want) begin
            failures++; $display("FAIL sw_value actual=%h required=%h", act_vec[8:0], want);
          end
        end
      end
    end
    checks++;
    if (changes !== 1 || cidx !== D + 2 || exp_q.size() != 0) begin
      failures++; $display("FAIL sw_timing count=%0d idx=%0d pending=%0d required count=1 idx=%0d pending=0",
                           changes, cidx, exp_q.size(), D + 2);
    end
    glitches = 0;
    for (int k = 0; k < 20; k++) begin
      ic.din_raw = (k < 2) ? 4'b0101 : 4'b1011;
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec) begin
        failures++; $display("FAIL glitch_model k=%0d actual=%h required=%h", k, act_vec, exp_vec);
      end
      if (ic.sw_changed) glitches++;
    end
    checks++;
    if (glitches !== 0 || ic.din_db !== 4'b1011) begin
      failures++; $display("FAIL glitch_reject changes=%0d din_db=%b required changes=0 din_db=1011", glitches, ic.din_db);
    end
  endtask

  task automatic test_concurrent;
    int pidx, cidx;
    pidx = -1; cidx = -1;
    ic.ms_raw   = 3'b101;
    ic.next_raw = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec) begin
        failures++; $display("FAIL conc_model k=%0d actual=%h required=%h", k, act_vec, exp_vec);
      end
      if (ic.next_pulse) pidx = k;
      if (ic.sw_changed) cidx = k;
    end
    checks++;
    if (pidx !== D + 2 || cidx !== D + 2 || ic.ms_db !== 3'b101) begin
      failures++; $display("FAIL conc_pulses pulse=%0d change=%0d ms_db=%b required both=%0d ms_db=101",
                           pidx, cidx, ic.ms_db, D + 2);
    end
    ic.next_raw = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec) begin
        failures++; $display("FAIL conc_release k=%0d actual=%h required=%h", k, act_vec, exp_vec);
      end
    end
  endtask

  task automatic test_mid_reset;
    int first_pulse;
    ic.next_raw = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec || ic.next_pulse !== 1'b0) begin
        failures++; $display("FAIL midrst_pre k=%0d actual=%h required=%h", k, act_vec, exp_vec);
      end
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (act_vec !== 12'h000) begin
      failures++; $display("FAIL midrst_clear actual=%h required=%h", act_vec, 12'h000);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (act_vec !== 12'h000) begin
      failures++; $display("FAIL midrst_hold actual=%h required=%h", act_vec, 12'h000);
    end
    rst = 1'b1;
    first_pulse = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec) begin
        failures++; $display("FAIL midrst_model k=%0d actual=%h required=%h", k, act_vec, exp_vec);
      end
      if (ic.next_pulse && first_pulse < 0) first_pulse = k;
    end
    checks++;
    if (first_pulse !== D + 2) begin
      failures++; $display("FAIL midrst_first_pulse actual=%0d required=%0d", first_pulse, D + 2);
    end
    ic.next_raw = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random;
    logic [8:0] v;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 7) == 0) ic.next_raw = ~ic.next_raw;
      if ($urandom_range(0, 11) == 0) begin
        v = 9'($urandom);
        set_sw(v[8], v[7], v[6:4], v[3:0]);
      end
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec) begin
        failures++; $display("FAIL random_model k=%0d actual=%h required=%h", k, act_vec, exp_vec);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    ic.next_raw = 1'b1;
    set_sw(1'b0, 1'b0, 3'h0, 4'h0);
    test_reset();
    test_clean_press();
    test_bounce();
    test_switch();
    test_concurrent();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage that sits directly upstream of the calculator core (FSM + Datapath + display encoders).
- Cleans the raw board inputs before the core sees them:
  - Active-low "next" pushbutton becomes a single-cycle debounced step pulse.
  - Switch bank (clear, level, MS, Din) becomes a synchronized, debounced, glitch-free bus.
- Removes metastability and contact bounce, so the core FSM advances exactly once per physical press.

Parameters:
- DEBOUNCE_CYCLES, default 250000: cycles an input must stay stable before it is accepted (5 ms at 50 MHz). Legal range ≥ 2.
- CNT_W, default 18: debounce counter width. Must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- next_raw  in  1  raw pushbutton, active-low (0 = pressed)
- clear_raw  in  1  raw clear switch, active-high
- level_raw  in  1  raw level switch
- ms_raw  in  3  raw mode-select switches
- din_raw  in  4  raw data switches
- next_pulse  out  1  one-cycle pulse per accepted press
- next_held  out  1  high while debounced button is pressed
- clear_db  out  1  debounced clear
- level_db  out  1  debounced level
- ms_db  out  3  debounced MS
- din_db  out  4  debounced Din
- sw_changed  out  1  one-cycle pulse when any debounced switch output updates

Behaviour:
- Reset: asynchronous, active-low. While rst=0:
  - All outputs are 0.
  - next_raw synchronizer flops load 1 (released).
  - Switch synchronizer flops load 0.
  - Both counters load 0; the button FSM is in IDLE.
- Reset asserted mid-operation aborts any pending press or switch update. No pulse is emitted on reset release.
- Synchronization: every raw input passes through two flops. All logic below uses the second-stage value only.
- Button FSM (4 states, one counter):
  - IDLE: if the synced button is 0, go to PRESS_WAIT with cnt=0.
  - PRESS_WAIT:
    - Synced button = 1 (bounce): return to IDLE, no pulse.
    - Otherwise cnt increments each cycle.
    - When cnt = DEBOUNCE_CYCLES-1 and the button is still 0: go to HELD and register next_pulse=1 for exactly one cycle.
  - HELD: next_held=1. If the synced button is 1, go to RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT: next_held stays 1.
    - Synced button = 0: return to HELD, no new pulse.
    - At cnt = DEBOUNCE_CYCLES-1 with the button still 1: go to IDLE and drop next_held.
- Button latency: take edge 0 as the first clk edge that samples next_raw=0 after a clean press. next_pulse is high for the single cycle following edge DEBOUNCE_CYCLES+2.
- A press held indefinitely yields exactly one pulse. Release bounce never generates a second pulse.
- Switch group: the 9-bit vector {clear, level, ms[2:0], din[3:0]} is debounced as one unit with its own counter.
  - If the synced vector differs from its value on the previous cycle: scnt is cleared to 0.
  - Else, if scnt < DEBOUNCE_CYCLES-1: scnt increments.
  - When scnt = DEBOUNCE_CYCLES-1 and the synced vector ≠ the registered outputs: load all *_db outputs together in one cycle and pulse sw_changed for that cycle.
  - If the vector equals the outputs, nothing happens (no pulse).
- Switch latency: a clean change is reflected DEBOUNCE_CYCLES+2 edges after it is first sampled.
- Simultaneous events: the button and switch paths are independent. next_pulse and sw_changed may assert in the same cycle.
- Counters saturate and never wrap. The counter compare uses equality against DEBOUNCE_CYCLES-1 at width CNT_W.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
- Reset: drive rst=0 with next_raw=0 and all switches 1, then release → all outputs stay 0. The first next_pulse appears only after a full debounce, measured from reset release.
- Clean press: next_raw 1→0 and hold for 20 cycles → next_pulse high for exactly 1 cycle, after edge 6. next_held is high from the same cycle until the release debounce completes.
- Bounce: next_raw toggles 0,1,0,1 at 2-cycle intervals, then stays 0 → exactly one next_pulse, 6 edges after the final stable 0. Release bounce of 1,0,1 yields no extra pulse.
- Switch update: din_raw 0000→1011 held steady → din_db=1011 and a one-cycle sw_changed 6 edges later. A 2-cycle glitch to 0101 produces no output change.
- Concurrent events: ms_raw changes in the same cycle as a press → ms_db and sw_changed update independently of next_pulse, with both pulses in the same cycle.
- Mid-operation reset: assert rst=0 during PRESS_WAIT with cnt=2 → no pulse, outputs are 0. After release, a new full debounce is required before any pulse.
